// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: instruction bit positions, FSM states and instruction builder for the feeder
package mac_feeder_pkg;
  localparam int INST_LOAD_W = 0;
  localparam int INST_PASS = 1;
  localparam int INST_ACC_N = 2;
  localparam int INST_SIMD = 3;
  typedef enum logic [1:0] {IDLE, WAIT, STREAM, FLUSH} state_t;
  function automatic logic [3:0] make_inst(input logic op, input logic simd, input logic acc);
    logic [3:0] w;
    w = '0;
    w[INST_LOAD_W] = ~op;
    w[INST_PASS] = op;
    w[INST_ACC_N] = op & acc;
    w[INST_SIMD] = simd;
    return w;
  endfunction
endpackage

// File: rtl/feeder_fifo.sv
// feeder_fifo: power-of-two synchronous FIFO with occupancy, full and sticky overflow
module feeder_fifo #(
  parameter int width = 32,
  parameter int depth = 64,
  parameter int cnt_bw = $clog2(depth + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [width-1:0]  din,
  output logic [width-1:0]  dout,
  output logic              full,
  output logic              ovf,
  output logic [cnt_bw-1:0] count
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [cnt_bw-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, push, pop;
  assign full = cnt_q == cnt_bw'(depth);
  assign count = cnt_q;
  assign ovf = ovf_q;
  assign dout = mem[rp_q];
  // A push while full is dropped even if a pop frees a slot this cycle
  always_comb begin
    push = wr & ~full;
    pop = rd & (cnt_q != '0);
    wp_d = wp_q + aw'(push);
    rp_d = rp_q + aw'(pop);
    cnt_d = cnt_q + cnt_bw'(push) - cnt_bw'(pop);
    ovf_d = ovf_q | (wr & full);
  end
  // Storage array needs no reset; only pointers and count define emptiness
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= din;
  end
  // Pointer, occupancy and overflow state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: buffers row vectors and streams skewed instruction/nibble diagonals into mac_array
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int rows = 8,
  parameter int inst_bw = 16,
  parameter int depth = 64,
  parameter int len_bw = $clog2(depth + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [4*rows-1:0]       in_d,
  output logic                    full,
  output logic                    ovf,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [len_bw-1:0]       cmd_len,
  input  logic                    cmd_simd,
  input  logic                    cmd_acc,
  output logic [4*rows-1:0]       out_w,
  output logic [inst_bw*rows-1:0] ii_w,
  output logic                    done,
  output logic [len_bw-1:0]       count
);
  state_t state_q, state_d;
  logic [len_bw-1:0] cnt_q, cnt_d, len_q, len_d;
  logic op_q, op_d, simd_q, simd_d, acc_q, acc_d, pop;
  logic [4*rows-1:0] fifo_dout, vec_q, vec_d;
  logic [inst_bw-1:0] ii_q [rows];
  logic [inst_bw-1:0] ii_d [rows];
  feeder_fifo #(.width(4 * rows), .depth(depth), .cnt_bw(len_bw)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .rd(pop),
    .din(in_d),
    .dout(fifo_dout),
    .full(full),
    .ovf(ovf),
    .count(count)
  );
  assign cmd_ready = state_q == IDLE;
  assign pop = state_d == STREAM;
  // Command FSM; cnt counts remaining stream cycles, then the rows+1 cycle drain
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    len_d = len_q;
    simd_d = simd_q;
    acc_d = acc_q;
    done = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d = cmd_op;
        len_d = cmd_len;
        simd_d = cmd_simd;
        acc_d = cmd_acc;
        state_d = WAIT;
      end
      WAIT: if (count >= len_q) begin
        state_d = len_q == '0 ? FLUSH : STREAM;
        cnt_d = len_q == '0 ? len_bw'(rows) : len_q;
      end
      STREAM: begin
        state_d = cnt_q == len_bw'(1) ? FLUSH : STREAM;
        cnt_d = cnt_q == len_bw'(1) ? len_bw'(rows) : cnt_q - 1'b1;
      end
      FLUSH: begin
        state_d = cnt_q == '0 ? IDLE : FLUSH;
        done = cnt_q == '0;
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Row-0 instruction and popped vector are registered one cycle ahead of STREAM so S lands at T+2
  always_comb begin
    ii_d[0] = pop ? inst_bw'(make_inst(op_q, simd_q, acc_q)) : '0;
    for (int i = 1; i < rows; i++) ii_d[i] = ii_q[i-1];
    vec_d = pop ? fifo_dout : '0;
  end
  // FSM state, latched command and the shared instruction/vector stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= 1'b0;
      len_q <= '0;
      simd_q <= 1'b0;
      acc_q <= 1'b0;
      vec_q <= '0;
      for (int i = 0; i < rows; i++) ii_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      len_q <= len_d;
      simd_q <= simd_d;
      acc_q <= acc_d;
      vec_q <= vec_d;
      for (int i = 0; i < rows; i++) ii_q[i] <= ii_d[i];
    end
  end
  for (genvar i = 0; i < rows; i++) begin : g_row
    logic [4*(i+1)-1:0] sr_q, sr_d;
    assign sr_d = (4 * (i + 1))'({sr_q, vec_q[4*i+:4]});
    assign out_w[4*i+:4] = sr_q[4*i+:4];
    assign ii_w[inst_bw*i+:inst_bw] = ii_q[i];
    // Row i nibble delay line: i+1 stages after the shared popped-vector stage
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sr_q <= '0;
      else sr_q <= sr_d;
    end
  end
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: scoreboard bench; expected diagonals are scheduled from a queue of pushed vectors
module tb_mac_feeder;
  localparam int rows = 8, inst_bw = 16, depth = 64, len_bw = $clog2(depth + 1);
  localparam int N = 4096, BIG = 1 << 30;
  logic clk = 0, reset = 1, wr = 0, cmd_valid = 0, cmd_op = 0, cmd_simd = 0, cmd_acc = 0;
  logic [4*rows-1:0] in_d = '0;
  logic [len_bw-1:0] cmd_len = '0;
  logic full, ovf, cmd_ready, done;
  logic [4*rows-1:0] out_w;
  logic [inst_bw*rows-1:0] ii_w;
  logic [len_bw-1:0] count;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [inst_bw*rows-1:0] e_ii [N];
  logic [4*rows-1:0] e_out [N];
  bit e_done [N], e_pop [N], e_rdy [N], e_full [N], e_ovf [N];
  int e_cnt [N];
  logic [4*rows-1:0] exp_q [$];
  int mcnt = 0, busy_from = BIG, busy_to = -1, p_t = 0, p_len = 0;
  bit pend = 0, ovf_m = 0, p_op = 0, p_simd = 0, p_acc = 0;

  mac_feeder dut (
    .clk(clk), .reset(reset), .wr(wr), .in_d(in_d), .full(full), .ovf(ovf),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_simd(cmd_simd), .cmd_acc(cmd_acc), .out_w(out_w), .ii_w(ii_w), .done(done), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) if (cyc < N) begin
    check("ii_w", ii_w, e_ii[cyc]);
    check("out_w", out_w, e_out[cyc]);
    check("done", done, e_done[cyc]);
    check("count", count, e_cnt[cyc]);
    check("cmd_ready", cmd_ready, e_rdy[cyc]);
    check("full", full, e_full[cyc]);
    check("ovf", ovf, e_ovf[cyc]);
  end

  task automatic sched(input int s);
    logic [inst_bw-1:0] w;
    logic [4*rows-1:0] v;
    w = '0;
    if (p_op) begin
      w[1] = 1'b1;
      w[2] = p_acc;
    end else w[0] = 1'b1;
    w[3] = p_simd;
    for (int k = 0; k < p_len; k++) begin
      v = exp_q.pop_front();
      e_pop[s-1+k] = 1;
      for (int i = 0; i < rows; i++) begin
        e_ii[s+i+k][inst_bw*i+:inst_bw] = w;
        e_out[s+1+k+i][4*i+:4] = v[4*i+:4];
      end
    end
    e_done[s+p_len+rows] = 1;
    busy_to = s + p_len + rows;
  endtask

  task automatic step();
    int c;
    bit push_ok;
    c = cyc;
    if (reset) begin
      exp_q.delete();
      mcnt = 0; ovf_m = 0; pend = 0; busy_from = BIG; busy_to = -1;
      for (int j = c; j < N; j++) begin
        e_ii[j] = '0; e_out[j] = '0; e_done[j] = 0; e_pop[j] = 0;
      end
      e_cnt[c] = 0; e_rdy[c] = 1; e_full[c] = 0; e_ovf[c] = 0;
      return;
    end
    e_cnt[c] = mcnt;
    e_full[c] = mcnt == depth;
    e_ovf[c] = ovf_m;
    e_rdy[c] = !(c >= busy_from && c <= busy_to);
    if (cmd_valid && e_rdy[c]) begin
      pend = 1; p_t = c; p_op = cmd_op; p_len = int'(cmd_len); p_simd = cmd_simd; p_acc = cmd_acc;
      busy_from = c + 1; busy_to = BIG;
    end
    if (pend && c > p_t && mcnt >= p_len) begin
      pend = 0;
      sched(c + 1);
    end
    push_ok = wr && mcnt < depth;
    if (wr && !push_ok) ovf_m = 1;
    if (push_ok) exp_q.push_back(in_d);
    mcnt = mcnt + int'(push_ok) - int'(e_pop[c]);
  endtask

  task automatic cyc_end();
    step();
    @(posedge clk);
    #1;
    wr = 0;
    cmd_valid = 0;
  endtask

  function automatic bit idle_now();
    return !pend && cyc > busy_to;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!idle_now() && n < 300) begin
      cyc_end();
      n++;
    end
    if (!idle_now()) check("idle_timeout", 0, 1);
  endtask

  task automatic push(input logic [4*rows-1:0] v);
    wr = 1;
    in_d = v;
    cyc_end();
  endtask

  task automatic issue(input logic op, input int len, input logic simd, input logic acc);
    wait_idle();
    cmd_op = op;
    cmd_len = len_bw'(len);
    cmd_simd = simd;
    cmd_acc = acc;
    cmd_valid = 1;
    cyc_end();
  endtask

  initial begin
    int ncmd;
    repeat (3) cyc_end();
    reset = 0;
    repeat (8) push(32'h7654_3210);
    issue(0, 8, 0, 0);
    wait_idle();
    repeat (2) push($urandom);
    issue(1, 4, 1, 1);
    repeat (5) cyc_end();
    repeat (2) push($urandom);
    wait_idle();
    repeat (depth + 1) push($urandom);
    repeat (2) cyc_end();
    issue(0, depth, 0, 0);
    wait_idle();
    repeat (8) push($urandom);
    ncmd = 0;
    for (int n = 0; n < 80; n++) begin
      if (mcnt < 40) begin
        wr = 1;
        in_d = $urandom;
      end
      if (ncmd < 2 && idle_now()) begin
        cmd_op = ncmd[0];
        cmd_len = 8;
        cmd_simd = 0;
        cmd_acc = ncmd[0];
        cmd_valid = 1;
        ncmd++;
      end
      cyc_end();
    end
    wait_idle();
    issue(0, 0, 0, 0);
    wait_idle();
    issue(1, 10, 0, 1);
    repeat (4) cyc_end();
    reset = 1;
    wr = 1;
    in_d = $urandom;
    cyc_end();
    cyc_end();
    reset = 0;
    repeat (15) cyc_end();
    repeat (3) push($urandom);
    issue(0, 3, 1, 0);
    wait_idle();
    repeat (2) cyc_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
